// File: rtl/rect_pkg.sv
// Shared constants and state type for the rectangle command decoder.
package rect_pkg;

  localparam logic [7:0] OP_RECT   = 8'h01;
  localparam logic [7:0] OP_CLEAR  = 8'h02;
  localparam logic [7:0] SYNC_BYTE = 8'hFF;

  localparam logic [1:0] CMD_RECT  = 2'd0;
  localparam logic [1:0] CMD_CLEAR = 2'd1;

  localparam logic [2:0] RECT_FIELDS  = 3'd5;
  localparam logic [2:0] CLEAR_FIELDS = 3'd1;

  typedef enum logic [1:0] {
    StHunt,
    StOpcode,
    StField,
    StComplete
  } dec_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Synchroniser and falling-edge detector for an asynchronous active-low byte strobe.
module strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic bstb
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      bstb   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
      bstb   <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/rect_cmd_decoder.sv
// Frames 0xFF-delimited byte commands into clamped, ordered rectangle/clear commands
// and presents them on a valid/ready output register.
module rect_cmd_decoder
  import rect_pkg::*;
#(
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned COLOR_W     = 6,
  parameter int unsigned X_SHIFT     = 1,
  parameter int unsigned X_MAX       = 319,
  parameter int unsigned Y_MAX       = 239,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         data,
  input  logic               dR,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [X_W-1:0]     x1,
  output logic [X_W-1:0]     x2,
  output logic [Y_W-1:0]     y1,
  output logic [Y_W-1:0]     y2,
  output logic [COLOR_W-1:0] color,
  output logic               overflow,
  output logic [7:0]         err_count
);

  localparam logic [X_W:0]   XMaxWide = (X_W+1)'(X_MAX);
  localparam logic [Y_W-1:0] YMax     = Y_W'(Y_MAX);

  logic               bstb;
  dec_state_t         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         kind_q, kind_d;
  logic [7:0]         fld_q [4];
  logic [COLOR_W-1:0] col_q;
  logic               err_inc, fld_we, col_we, load, drop;

  strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk   (CLOCK_50),
    .rst   (reset),
    .strobe(dR),
    .bstb  (bstb)
  );

  // Scaling is done one bit wider so the shifted byte cannot wrap before the clamp.
  function automatic logic [X_W-1:0] scale_x(input logic [7:0] b);
    logic [X_W:0] xs;
    xs = (X_W+1)'(b) << X_SHIFT;
    return (xs > XMaxWide) ? XMaxWide[X_W-1:0] : xs[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] scale_y(input logic [7:0] b);
    logic [Y_W-1:0] ys;
    ys = Y_W'(b);
    return (ys > YMax) ? YMax : ys;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    err_inc = 1'b0;
    fld_we  = 1'b0;
    col_we  = 1'b0;
    if (bstb && data == SYNC_BYTE) begin
      state_d = StOpcode;
      idx_d   = 3'd0;
      err_inc = (state_q == StField);
    end else begin
      unique case (state_q)
        StHunt: ;
        StOpcode: begin
          if (bstb) begin
            if (data == OP_RECT) begin
              state_d = StField;
              cnt_d   = RECT_FIELDS;
              kind_d  = CMD_RECT;
            end else if (data == OP_CLEAR) begin
              state_d = StField;
              cnt_d   = CLEAR_FIELDS;
              kind_d  = CMD_CLEAR;
            end else begin
              state_d = StHunt;
              err_inc = 1'b1;
            end
          end
        end
        StField: begin
          if (bstb) begin
            // The last field of every opcode is the colour.
            if (idx_q == cnt_q - 3'd1) begin
              col_we  = 1'b1;
              state_d = StComplete;
            end else begin
              fld_we = 1'b1;
              idx_d  = idx_q + 3'd1;
            end
          end
        end
        StComplete: begin
          state_d = StOpcode;
          idx_d   = 3'd0;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StHunt;
      idx_q   <= 3'd0;
      cnt_q   <= 3'd0;
      kind_q  <= CMD_RECT;
      col_q   <= '0;
      for (int i = 0; i < 4; i++) fld_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      if (fld_we) fld_q[idx_q[1:0]] <= data;
      if (col_we) col_q <= data[COLOR_W-1:0];
    end
  end

  logic [X_W-1:0] xa, xb, nx1, nx2;
  logic [Y_W-1:0] ya, yb, ny1, ny2;

  assign xa = scale_x(fld_q[0]);
  assign xb = scale_x(fld_q[1]);
  assign ya = scale_y(fld_q[2]);
  assign yb = scale_y(fld_q[3]);

  always_comb begin
    nx1 = (xa < xb) ? xa : xb;
    nx2 = (xa < xb) ? xb : xa;
    ny1 = (ya < yb) ? ya : yb;
    ny2 = (ya < yb) ? yb : ya;
    if (kind_q == CMD_CLEAR) begin
      nx1 = '0;
      nx2 = XMaxWide[X_W-1:0];
      ny1 = '0;
      ny2 = YMax;
    end
  end

  // A held command may be replaced in the same cycle the consumer takes it.
  assign load = (state_q == StComplete) && (!cmd_valid || cmd_ready);
  assign drop = (state_q == StComplete) && !load;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      color     <= '0;
      overflow  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_op    <= kind_q;
        x1        <= nx1;
        x2        <= nx2;
        y1        <= ny1;
        y2        <= ny2;
        color     <= col_q;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rect_cmd_decoder.sv
// Randomised, model-checked bench for rect_cmd_decoder with directed anchor frames.
module tb_rect_cmd_decoder;

  localparam int X_W = 9, Y_W = 8, COLOR_W = 6, X_SHIFT = 1;
  localparam int X_MAX = 319, Y_MAX = 239, SYNC_STAGES = 2;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         data = 8'd0;
  logic               dR = 1'b1;
  logic               cmd_ready = 1'b0;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [X_W-1:0]     x1, x2;
  logic [Y_W-1:0]     y1, y2;
  logic [COLOR_W-1:0] color;
  logic               overflow;
  logic [7:0]         err_count;

  rect_cmd_decoder #(
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .X_SHIFT(X_SHIFT),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .data     (data),
    .dR       (dR),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .x1       (x1),
    .x2       (x2),
    .y1       (y1),
    .y2       (y2),
    .color    (color),
    .overflow (overflow),
    .err_count(err_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;

  typedef struct {int op; int x1; int x2; int y1; int y2; int color;} cmd_t;
  typedef struct {int cyc; bit is_err; cmd_t c;} ev_t;

  int checks = 0;
  int failures = 0;

  // Model: framing state, timed events, and the expected output register.
  int   mode = 0;        // 0 hunting, 1 expecting opcode, 2 collecting fields
  int   m_op = 0, m_need = 0, m_got = 0;
  int   fb[5];
  ev_t  evq[$];
  bit   m_valid = 0, m_ovf = 0;
  int   m_err = 0;
  cmd_t m_cmd;
  cmd_t acc_q[$];
  bit   rnd_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int b);
    int v = b << X_SHIFT;
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic int sy(input int b);
    return (b > Y_MAX) ? Y_MAX : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // k is the cycle count at which dR fell; the byte acts SYNC_STAGES+2 edges later.
  task automatic model_byte(input int b, input int k);
    ev_t e;
    e.is_err = 0;
    e.c = '{default: 0};
    if (b == 255) begin
      if (mode == 2) begin
        e.cyc = k + SYNC_STAGES + 2;
        e.is_err = 1;
        evq.push_back(e);
      end
      mode = 1;
      m_got = 0;
    end else if (mode == 1) begin
      if (b == 1 || b == 2) begin
        m_op = b - 1;
        m_need = (b == 1) ? 5 : 1;
        m_got = 0;
        mode = 2;
      end else begin
        e.cyc = k + SYNC_STAGES + 2;
        e.is_err = 1;
        evq.push_back(e);
        mode = 0;
      end
    end else if (mode == 2) begin
      fb[m_got] = b;
      m_got++;
      if (m_got == m_need) begin
        if (m_op == 0) begin
          e.c.op = 0;
          e.c.x1 = imin(sx(fb[0]), sx(fb[1]));
          e.c.x2 = imax(sx(fb[0]), sx(fb[1]));
          e.c.y1 = imin(sy(fb[2]), sy(fb[3]));
          e.c.y2 = imax(sy(fb[2]), sy(fb[3]));
        end else begin
          e.c.op = 1;
          e.c.x1 = 0;
          e.c.x2 = X_MAX;
          e.c.y1 = 0;
          e.c.y2 = Y_MAX;
        end
        e.c.color = fb[m_need-1] % (1 << COLOR_W);
        e.cyc = k + SYNC_STAGES + 3;
        evq.push_back(e);
        mode = 1;
        m_got = 0;
      end
    end
  endtask

  // Advance the expected output register across edge c.
  task automatic model_step(input int c);
    bit   ld = 0;
    cmd_t nc;
    nc = '{default: 0};
    while (evq.size() > 0 && evq[0].cyc == c) begin
      if (evq[0].is_err) begin
        if (m_err < 255) m_err++;
      end else begin
        ld = 1;
        nc = evq[0].c;
      end
      void'(evq.pop_front());
    end
    if (ld) begin
      if (!m_valid || cmd_ready) begin
        m_valid = 1;
        m_cmd = nc;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && cmd_ready) begin
      m_valid = 0;
    end
  endtask

  always @(negedge CLOCK_50) begin
    cmd_t dc;
    if (reset) begin
      m_valid = 0;
      m_ovf = 0;
      m_err = 0;
      evq.delete();
    end
    chk("cmd_valid", int'(cmd_valid), int'(m_valid));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("err_count", int'(err_count), m_err);
    if (m_valid) begin
      chk("cmd_op", int'(cmd_op), m_cmd.op);
      chk("x1", int'(x1), m_cmd.x1);
      chk("x2", int'(x2), m_cmd.x2);
      chk("y1", int'(y1), m_cmd.y1);
      chk("y2", int'(y2), m_cmd.y2);
      chk("color", int'(color), m_cmd.color);
    end
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        dc = '{op: int'(cmd_op), x1: int'(x1), x2: int'(x2), y1: int'(y1), y2: int'(y2),
               color: int'(color)};
        acc_q.push_back(dc);
      end
      model_step(cyc + 1);
    end
  end

  initial begin
    forever begin
      @(posedge CLOCK_50);
      #5;
      if (rnd_ready) cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input int b);
    @(posedge CLOCK_50);
    #5;
    data = b[7:0];
    dR = 1'b0;
    model_byte(b, cyc);
    repeat (4) @(posedge CLOCK_50);
    #5;
    dR = 1'b1;
    repeat (3) @(posedge CLOCK_50);
  endtask

  task automatic send_seq(input int q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  task automatic set_ready(input bit r);
    @(posedge CLOCK_50);
    #5;
    cmd_ready = r;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(cmd_valid), 0);
    chk({tag, "_op"}, int'(cmd_op), 0);
    chk({tag, "_x1"}, int'(x1), 0);
    chk({tag, "_x2"}, int'(x2), 0);
    chk({tag, "_y1"}, int'(y1), 0);
    chk({tag, "_y2"}, int'(y2), 0);
    chk({tag, "_color"}, int'(color), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_err"}, int'(err_count), 0);
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #5;
    reset = 1'b1;
    mode = 0;
    m_got = 0;
    #1;
    chk_zero("rst_async");
    repeat (2) @(posedge CLOCK_50);
    #5;
    reset = 1'b0;
  endtask

  task automatic chk_acc(input string tag, input int idx, input int op, input int ex1,
                         input int ex2, input int ey1, input int ey2, input int ecol);
    if (acc_q.size() <= idx) begin
      chk({tag, "_present"}, acc_q.size(), idx + 1);
    end else begin
      chk({tag, "_op"}, acc_q[idx].op, op);
      chk({tag, "_x1"}, acc_q[idx].x1, ex1);
      chk({tag, "_x2"}, acc_q[idx].x2, ex2);
      chk({tag, "_y1"}, acc_q[idx].y1, ey1);
      chk({tag, "_y2"}, acc_q[idx].y2, ey2);
      chk({tag, "_color"}, acc_q[idx].color, ecol);
    end
  endtask

  initial begin
    int seq[$];
    int r, n;
    repeat (2) @(posedge CLOCK_50);
    #5;
    chk_zero("rst_init");
    reset = 1'b0;
    set_ready(1'b1);

    acc_q.delete();
    seq = '{255, 1, 10, 5, 20, 30, 42};
    send_seq(seq);
    idle(6);
    chk("rect_count", acc_q.size(), 1);
    chk_acc("rect", 0, 0, 10, 20, 20, 30, 42);

    acc_q.delete();
    seq = '{255, 1, 200, 16, 245, 3, 7};
    send_seq(seq);
    idle(6);
    chk("clamp_count", acc_q.size(), 1);
    chk_acc("clamp", 0, 0, 32, 319, 3, 239, 7);

    acc_q.delete();
    seq = '{255, 2, 21, 1, 1, 2, 3, 4, 5};
    send_seq(seq);
    idle(6);
    chk("b2b_count", acc_q.size(), 2);
    chk_acc("b2b_clear", 0, 1, 0, 319, 0, 239, 21);
    chk_acc("b2b_rect", 1, 0, 2, 4, 3, 4, 5);

    acc_q.delete();
    seq = '{255, 1, 10, 255, 2, 3};
    send_seq(seq);
    idle(6);
    chk("abort_err", int'(err_count), 1);
    chk("abort_count", acc_q.size(), 1);
    chk_acc("abort_clear", 0, 1, 0, 319, 0, 239, 3);

    acc_q.delete();
    seq = '{255, 7, 1, 10, 5, 20, 30, 42};
    send_seq(seq);
    idle(6);
    chk("badop_err", int'(err_count), 2);
    chk("badop_count", acc_q.size(), 0);

    acc_q.delete();
    set_ready(1'b0);
    seq = '{255, 1, 10, 5, 20, 30, 42, 1, 2, 4, 6, 8, 9};
    send_seq(seq);
    idle(6);
    chk("bp_ovf", int'(overflow), 1);
    chk("bp_valid", int'(cmd_valid), 1);
    chk("bp_held_x1", int'(x1), 10);
    chk("bp_held_color", int'(color), 42);
    set_ready(1'b1);
    idle(4);
    chk("bp_count", acc_q.size(), 1);
    chk_acc("bp_first", 0, 0, 10, 20, 20, 30, 42);
    chk("bp_drained", int'(cmd_valid), 0);

    seq = '{255, 1, 10};
    send_seq(seq);
    do_reset();
    acc_q.delete();
    seq = '{10, 5, 20, 30, 42};
    send_seq(seq);
    idle(6);
    chk("postrst_count", acc_q.size(), 0);
    chk("postrst_valid", int'(cmd_valid), 0);

    rnd_ready = 1;
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_byte(255);
        send_byte($urandom_range(3, 254));
      end else if (r == 1) begin
        send_byte(255);
        send_byte(1);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) send_byte($urandom_range(0, 254));
      end else begin
        if (r < 6) send_byte(255);
        send_byte((r < 4) ? 2 : 1);
        n = (r < 4) ? 1 : 5;
        for (int i = 0; i < n; i++) send_byte($urandom_range(0, 254));
      end
    end
    rnd_ready = 0;
    set_ready(1'b1);
    idle(8);

    for (int i = 0; i < 260; i++) begin
      send_byte(255);
      send_byte(7);
    end
    idle(6);
    chk("err_saturate", int'(err_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
